vec_acc_engine: RTL and testbench
=================================

Name: vec_acc_engine

Overview:
- Accelerator that consumes the operand arrays driven by the RAM wrapper (acc_in_A / acc_in_B) and the start strobe, and returns the result array on acc_out.
- On a start rising edge it processes all NUM_WORDS words byte-wise, LANES words per cycle, then pulses done_o.
- Sits beside the single-port RAM wrapper as the responder end of its accelerator interface.

Parameters:
- NUM_WORDS, 256, number of 32-bit words per operand/result array; must be a multiple of LANES.
- LANES, 4, words processed per BUSY cycle; power of two, 1..NUM_WORDS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- start_i  input  1  start level from RAM wrapper; operation triggers on its 0->1 edge.
- op_i  input  2  operation select, sampled with the start edge.
- acc_in_A  input  [NUM_WORDS-1:0] x 4x8  operand A array.
- acc_in_B  input  [NUM_WORDS-1:0] x 4x8  operand B array.
- acc_out  output  [NUM_WORDS-1:0] x 4x8  registered result array.
- busy_o  output  1  high while the state is BUSY.
- done_o  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE, acc_out all 0, busy_o 0, done_o 0, word index 0, op register 0, start_q 0.
- start_q registers start_i every cycle. Edge = start_i & ~start_q.
- States and transitions:
  - IDLE: on edge, latch op_i, clear index, go to BUSY. No edge: stay in IDLE.
  - BUSY: each cycle, write acc_out[index+k] = f(A[index+k], B[index+k]) for k in 0..LANES-1, then index += LANES. When index == NUM_WORDS-LANES, go to DONE after this write.
  - DONE: done_o = 1 for exactly one cycle, then go to IDLE.
- Latency: edge sampled at edge T, BUSY for cycles T+1 .. T+NUM_WORDS/LANES, done_o high in the following cycle. Defaults give 64 BUSY cycles.
- Operations, applied independently per byte (no carries between bytes):
  - 00: add, modulo 256.
  - 01: unsigned saturating add, clamps at 0xFF (only with ACC_SAT_EN; see Optional Feature).
  - 10: multiply, keep low 8 bits of the product.
  - 11: XOR.
- Inputs acc_in_A / acc_in_B must stay stable while busy_o is high; the engine does not snapshot them.
- Words not yet processed keep their previous result; acc_out is not cleared at start.
- Start edges in BUSY or DONE are ignored. start_i held high across DONE->IDLE does not retrigger; a new 0->1 edge is required.
- op_i changes during BUSY have no effect.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. A partial result is discarded (cleared).
- Index wrap: index never exceeds NUM_WORDS-LANES. It is cleared on entry to BUSY.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: op 01 = per-byte unsigned saturating add, min(a+b, 255).
- Undefined: the saturation logic is not built and op 01 behaves as op 00 (modulo add).

Decomposition:
- Package acc_pkg holds:
  - acc_op_e enum (ACC_ADD, ACC_SADD, ACC_MUL, ACC_XOR).
  - acc_state_e enum (IDLE, BUSY, DONE).
  - acc_word_t typedef (logic [3:0][7:0]).
  - Default constants ACC_NUM_WORDS = 256, ACC_LANES = 4.
- Sub-module acc_lane: purely combinational 32-bit byte-wise ALU taking (op, a, b) and returning the result word. Instantiated LANES times in a generate loop. The top holds the FSM, index counter, start edge detect and result registers.

Test Plan:
- Reset then idle: rst_i pulsed, no start -> acc_out all 0, busy_o 0, done_o 0 for 100 cycles.
- Add wrap: A bytes 0xF0, B bytes 0x20, op 00, start 0->1 -> busy_o high exactly 64 cycles, then done_o high 1 cycle; every acc_out byte 0x10.
- Saturate: same operands, op 01 -> all bytes 0xFF with ACC_SAT_EN defined, 0x10 without it.
- Multiply/XOR per byte: A word i = {i,i,i,i} mod 256, B = 0x03030303, op 10 -> byte = (3*i) & 0xFF. Rerun with op 11 -> byte = i ^ 3. Check no cross-byte carry at i = 0x80.
- Ignored restart: a second start edge at BUSY cycle 10, plus start_i held high through DONE -> a single done_o pulse, no second run.
- Reset mid-op: rst_i asserted at BUSY cycle 30 -> acc_out all 0 and state IDLE immediately. A following start edge completes a full 64-cycle run with correct results.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared types and defaults for vec_acc_engine and its lane ALU.
package acc_pkg;
  typedef enum logic [1:0] {
    ACC_ADD  = 2'b00,
    ACC_SADD = 2'b01,
    ACC_MUL  = 2'b10,
    ACC_XOR  = 2'b11
  } acc_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } acc_state_e;
  typedef logic [3:0][7:0] acc_word_t;
  localparam int ACC_NUM_WORDS = 256;
  localparam int ACC_LANES     = 4;
endpackage

// File: rtl/acc_lane.sv
// acc_lane: combinational byte-wise ALU for one 32-bit word, no carries between bytes.
// ACC_SAT_EN builds the saturating add for op 01; otherwise op 01 is a modulo add.
module acc_lane
  import acc_pkg::*;
(
  input  acc_op_e   op_i,
  input  acc_word_t a_i,
  input  acc_word_t b_i,
  output acc_word_t y_o
);
  for (genvar i = 0; i < 4; i++) begin : g_b
`ifdef ACC_SAT_EN
    logic [8:0] s;
    assign s = {1'b0, a_i[i]} + {1'b0, b_i[i]};
    assign y_o[i] = op_i == ACC_MUL ? 8'(a_i[i] * b_i[i]) :
                    op_i == ACC_XOR ? a_i[i] ^ b_i[i] :
                    (op_i == ACC_SADD && s[8]) ? 8'hFF : s[7:0];
`else
    assign y_o[i] = op_i == ACC_MUL ? 8'(a_i[i] * b_i[i]) :
                    op_i == ACC_XOR ? a_i[i] ^ b_i[i] : a_i[i] + b_i[i];
`endif
  end
endmodule

// File: rtl/vec_acc_engine.sv
// vec_acc_engine: on a start rising edge, processes LANES words per cycle across the arrays, then pulses done_o.
// ACC_SAT_EN (in acc_lane) enables the saturating add for op 01.
module vec_acc_engine
  import acc_pkg::*;
#(
  parameter int NUM_WORDS = ACC_NUM_WORDS,
  parameter int LANES     = ACC_LANES
) (
  input  logic                          clk,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [1:0]                    op_i,
  input  logic [NUM_WORDS-1:0][3:0][7:0] acc_in_A,
  input  logic [NUM_WORDS-1:0][3:0][7:0] acc_in_B,
  output logic [NUM_WORDS-1:0][3:0][7:0] acc_out,
  output logic                          busy_o,
  output logic                          done_o
);
  localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - LANES);
  localparam logic [IW-1:0] STEP = IW'(LANES);
  acc_state_e state_q, state_d;
  acc_op_e op_q, op_d;
  logic [IW-1:0] idx_q, idx_d;
  logic start_q, busy_q, busy_d, done_q, done_d, start_edge;
  logic [NUM_WORDS-1:0][3:0][7:0] out_q, out_d;
  acc_word_t [LANES-1:0] res;
  assign start_edge = start_i & ~start_q;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    acc_lane u_lane (
      .op_i(op_q),
      .a_i (acc_in_A[idx_q + IW'(k)]),
      .b_i (acc_in_B[idx_q + IW'(k)]),
      .y_o (res[k])
    );
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (start_edge) begin
        state_d = BUSY;
        op_d    = acc_op_e'(op_i);
        idx_d   = '0;
      end
      BUSY: begin
        for (int k = 0; k < LANES; k++) out_d[idx_q + IW'(k)] = res[k];
        state_d = idx_q == LAST ? DONE : BUSY;
        idx_d   = idx_q == LAST ? idx_q : idx_q + STEP;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == BUSY;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= ACC_ADD;
      idx_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      start_q <= start_i;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end
  assign acc_out = out_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
endmodule

// File: tb/tb_vec_acc_engine.sv
// tb_vec_acc_engine: directed table of runs plus reset/restart sequences for vec_acc_engine.
module tb_vec_acc_engine;
  localparam int NW = 256;
  localparam int L  = 4;
`ifdef ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [1:0]  op;
    bit          pat;
    int          probe;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic [1:0] op_i = 2'b00;
  logic [NW-1:0][3:0][7:0] a_arr, b_arr, acc_out;
  logic busy_o, done_o;
  int total = 0, bad = 0;
  vec_t tbl[9];
  always #5 clk = ~clk;
  vec_acc_engine #(.NUM_WORDS(NW), .LANES(L)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .acc_in_A(a_arr), .acc_in_B(b_arr), .acc_out(acc_out),
    .busy_o(busy_o), .done_o(done_o)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] mb(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [15:0] p;
    s = {1'b0, a} + {1'b0, b};
    p = {8'h00, a} * {8'h00, b};
    case (op)
      2'b00: return s[7:0];
      2'b01: return (SAT && s[8]) ? 8'hFF : s[7:0];
      2'b10: return p[7:0];
      default: return a ^ b;
    endcase
  endfunction
  task automatic set_pat(input bit p);
    for (int i = 0; i < NW; i++) begin
      a_arr[i] = p ? {4{8'(i)}} : 32'hF0F0F0F0;
      b_arr[i] = p ? 32'h03030303 : 32'h20202020;
    end
  endtask
  task automatic chk_all(input logic [1:0] op, input string nm);
    int errs = 0;
    for (int w = 0; w < NW; w++)
      for (int j = 0; j < 4; j++)
        if (acc_out[w][j] !== mb(op, a_arr[w][j], b_arr[w][j])) errs++;
    chk(nm, errs, 0);
  endtask
  // start held high through DONE; op_i flipped during BUSY; optional extra start edge at BUSY cycle glitch+1
  task automatic run(input logic [1:0] op, input int glitch, input string nm);
    int nb = 0, nd = 0, dat = -1;
    @(negedge clk);
    op_i = op;
    start_i = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      nb += int'(busy_o);
      nd += int'(done_o);
      if (done_o && dat < 0) dat = c;
      if (c == 1) op_i = ~op;
      if (c == glitch) start_i = 1'b0;
      if (c == glitch + 1) start_i = 1'b1;
    end
    start_i = 1'b0;
    chk({nm, "_busy_cycles"}, nb, 64);
    chk({nm, "_done_pulses"}, nd, 1);
    chk({nm, "_done_at"}, dat, 64);
  endtask
  initial begin
    int errs;
    tbl[0] = '{2'b00, 1'b0, 5,    32'h10101010};
    tbl[1] = '{2'b01, 1'b0, 7,    SAT ? 32'hFFFFFFFF : 32'h10101010};
    tbl[2] = '{2'b10, 1'b1, 'h80, 32'h80808080};
    tbl[3] = '{2'b10, 1'b1, 'h55, 32'hFFFFFFFF};
    tbl[4] = '{2'b10, 1'b1, 'hFF, 32'hFDFDFDFD};
    tbl[5] = '{2'b11, 1'b1, 'h80, 32'h83838383};
    tbl[6] = '{2'b11, 1'b1, 'h03, 32'h00000000};
    tbl[7] = '{2'b00, 1'b1, 'hFE, 32'h01010101};
    tbl[8] = '{2'b01, 1'b1, 'hFE, SAT ? 32'hFFFFFFFF : 32'h01010101};
    set_pat(1'b0);
    repeat (3) @(negedge clk);
    chk("reset_out_zero", 32'(acc_out == '0), 1);
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_done", 32'(done_o), 0);
    rst_i = 1'b0;
    errs = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (acc_out != '0 || busy_o || done_o) errs++;
    end
    chk("idle_100", errs, 0);
    for (int v = 0; v < 9; v++) begin
      set_pat(tbl[v].pat);
      run(tbl[v].op, -1, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_probe", v), acc_out[tbl[v].probe], tbl[v].exp);
      chk_all(tbl[v].op, $sformatf("vec%0d_all", v));
    end
    set_pat(1'b0);
    run(2'b00, 10, "restart");
    chk("restart_probe", acc_out[200], 32'h10101010);
    set_pat(1'b1);
    @(negedge clk);
    op_i = 2'b10;
    start_i = 1'b1;
    repeat (31) @(negedge clk);
    chk("mid_busy_before", 32'(busy_o), 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_out_zero", 32'(acc_out == '0), 1);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_done", 32'(done_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy_o), 0);
    run(2'b11, -1, "after_rst");
    chk("after_rst_probe", acc_out['h80], 32'h83838383);
    chk_all(2'b11, "after_rst_all");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
